// File: rtl/bus_arbiter.sv
// Two-master arbiter (instruction fetch and data) onto one memory slave.
// Data normally wins ties, but a 4-bit starvation counter forces a fetch
// grant after STARVE_LIMIT consecutive data beats while fetch is waiting.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no owner, arbitrates every cycle
//   GNT_I | fetch master owns the slave until PREADY
//   GNT_D | data master owns the slave until PREADY
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          HTRANS_I,
  input  logic [AW-1:0] HADDR_I,
  input  logic          HTRANS_D,
  input  logic [AW-1:0] HADDR_D,
  input  logic          HWRITE_D,
  input  logic [AW-1:0] HWDATA_D,
  input  logic          PREADY,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic [AW-1:0] PDATA,
  output logic          HREADY_I,
  output logic          HREADY_D,
  output logic [1:0]    GNT,
  output logic          stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_starve;
  logic [3:0] w_starve_nxt;
  logic       w_arb;
  logic       w_ibeat;
  logic       w_dbeat;

  assign w_arb   = (r_state == IDLE) || PREADY;
  assign w_ibeat = (r_state == GNT_I) && PREADY;
  assign w_dbeat = (r_state == GNT_D) && PREADY;

  // Starvation count including the beat completing this cycle, so the
  // arbitration that closes the STARVE_LIMIT-th data beat already sees it.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!HTRANS_I || w_ibeat) begin
      w_starve_nxt = 4'd0;
    end else if (w_dbeat && (r_starve < LIMIT)) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  // Next owner: only re-decided at an arbitration point, never mid-beat.
  always_comb begin
    w_next = r_state;
    if (w_arb) begin
      if (HTRANS_D && HTRANS_I) begin
        w_next = (w_starve_nxt == LIMIT) ? GNT_I : GNT_D;
      end else if (HTRANS_D) begin
        w_next = GNT_D;
      end else if (HTRANS_I) begin
        w_next = GNT_I;
      end else begin
        w_next = IDLE;
      end
    end
  end

  // Registered owner; reset abandons any beat in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_starve <= 4'd0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  // Slave-side mux and master handshakes, driven purely by the owner.
  always_comb begin
    PADDR    = '0;
    PWRITE   = 1'b0;
    PDATA    = '0;
    HREADY_I = 1'b0;
    HREADY_D = 1'b0;
    GNT      = 2'b00;
    case (r_state)
      GNT_I: begin
        PADDR    = HADDR_I;
        HREADY_I = PREADY;
        GNT      = 2'b01;
      end
      GNT_D: begin
        PADDR    = HADDR_D;
        PWRITE   = HWRITE_D;
        PDATA    = HWDATA_D;
        HREADY_D = PREADY;
        GNT      = 2'b10;
      end
      default: ;
    endcase
  end

  // A pending request that is not completing this cycle stalls the pipe.
  always_comb begin
    stall = (HTRANS_I && !HREADY_I) || (HTRANS_D && !HREADY_D);
  end

endmodule
